mont_mul_arbiter: RTL and testbench
===================================

Name: mont_mul_arbiter

Overview:
Round-robin arbiter sharing one montgomery_mul instance between NREQ requesters, e.g. several exponentiation sequencers or a CPU-side wishbone slave plus a DMA path. It accepts one operand pair at a time, drives the multiplier start/operand inputs, and returns the result to the owning requester. A watchdog guards against a multiplier that never signals done. N and N_INV are wired straight from configuration to the multiplier and do not pass through this block.

Parameters:
WIDTH, 32, operand/result width; must equal the multiplier's WIDTH
NREQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 64, max cycles in WAIT before aborting (>=4)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request; held with operands until accepted
req_a  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
req_ready  out  NREQ  one-hot accept; transfer = req_valid[i] & req_ready[i]
rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the owner
rsp_data  out  WIDTH  result; valid only while any rsp_valid bit is high
rsp_err  out  1  high with rsp_valid when the op timed out
mm_start  out  1  one-cycle start pulse to the multiplier
mm_a  out  WIDTH  latched operand A, stable from ISSUE until the op completes
mm_b  out  WIDTH  latched operand B, same
mm_done  in  1  multiplier done pulse
mm_result  in  WIDTH  multiplier result, sampled when mm_done=1
busy  out  1  state != IDLE
owner  out  clog2(NREQ)  index of the current or last granted requester
err_count  out  8  saturating timeout counter

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, rr_ptr=0, owner=0, mm_a=mm_b=0, rsp_valid=0, rsp_data=0, rsp_err=0, err_count=0, timeout counter=0. Reset in any state, including WAIT, abandons the op with no response. A later mm_done from the abandoned op is ignored because it arrives outside WAIT.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - req_ready is combinational: one-hot grant g = first i with req_valid[i], searching from rr_ptr upward with wrap; zero when no request is valid.
  - On transfer: latch mm_a/mm_b from requester g, owner<=g, rr_ptr<=(g+1) mod NREQ, go to ISSUE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE: mm_start=1 for this cycle only, which is a decode of the registered state. Clear the timeout counter, go to WAIT.
- WAIT:
  - On mm_done: rsp_data<=mm_result, rsp_valid[owner]<=1, rsp_err<=0, go to IDLE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYC: rsp_valid[owner]<=1, rsp_err<=1, rsp_data<=0, err_count+=1 (saturating at 255), go to IDLE.
- Registered response:
  - rsp_valid/rsp_err are high during the first IDLE cycle after WAIT and clear the next cycle.
  - A new grant is allowed in that same cycle (back-to-back).
- Latency with a 3-cycle multiplier (done pulses 3 cycles after the start cycle):
  - accept at cycle 0, mm_start at cycle 1, mm_done at cycle 4, rsp_valid at cycle 5.
  - Throughput: 1 op per 5 cycles.
- mm_done outside WAIT is ignored and has no side effect.
- Fairness: a continuously-requesting requester waits at most NREQ-1 ops.
- Requesters must keep req_valid and operands stable until accepted. Dropping req_valid early is legal; it only forfeits the request.

Decomposition:
- Package mont_arb_pkg: state encoding constants (IDLE=0, ISSUE=1, WAIT=2), a clog2 function, and the err_count width.
- One sub-module, mont_rr_pick: combinational round-robin pick with inputs req vector and rr_ptr, outputs one-hot grant, grant index and any_valid. The pointer register stays in the parent.

Test Plan:
- Stub multiplier (result = a+b, done 3 cycles after start); req_valid[0] with a=5, b=7 -> req_ready[0] at cycle 0, mm_start at cycle 1, rsp_valid=4'b0001 at cycle 5, rsp_data=12, rsp_err=0.
- After reset, all four requesters valid with a=i, b=10 -> grants in order 0,1,2,3, rsp_data 10,11,12,13, each op 5 cycles apart, rr_ptr back to 0.
- req0 held continuously, req2 raised during req0's op -> next grant goes to 2, then 0. Requester 0 never gets two grants in a row while 2 is waiting.
- Stub never asserts done, TIMEOUT_CYC=16 -> rsp_valid[owner] and rsp_err=1 at cycle 18, rsp_data=0, err_count=1. A late mm_done produces no response.
- rst pulsed during WAIT -> all outputs zero the next cycle, the stale mm_done is ignored, and a new req1 (a=3, b=4) returns 7 normally.
- mm_done forced high while IDLE with no requests -> no rsp_valid, state stays IDLE, err_count unchanged.

Source files
------------

// File: rtl/mont_arb_pkg.sv
// Shared types and helpers for the Montgomery multiplier arbiter.
// State encoding, a constant-safe clog2, and the error counter width.
package mont_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int ERR_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mont_rr_pick.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr,
// wrapping around; the pointer register itself lives in the parent.
module mont_rr_pick
  import mont_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier between NREQ requesters,
// with a watchdog that aborts an op whose done pulse never arrives.
module mont_mul_arbiter
  import mont_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     mm_start,
  output logic [WIDTH-1:0]         mm_a,
  output logic [WIDTH-1:0]         mm_b,
  input  logic                     mm_done,
  input  logic [WIDTH-1:0]         mm_result,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   owner,
  output logic [ERR_W-1:0]         err_count
);

  localparam int IDX_W = clog2(NREQ);
  localparam int TMO_W = clog2(TIMEOUT_CYC + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [NREQ-1:0]    pick_grant;
  logic               pick_any;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               accept;
  logic               done_ok;
  logic               tmo_hit;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  mont_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    mm_start  = 1'b0;
    accept    = 1'b0;
    done_ok   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mm_start  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (mm_done) begin
          done_ok   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Registered grant, watchdog and response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      mm_a      <= '0;
      mm_b      <= '0;
      tmo_cnt   <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      err_count <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        mm_a   <= req_a[pick_idx*WIDTH +: WIDTH];
        mm_b   <= req_b[pick_idx*WIDTH +: WIDTH];
        owner  <= pick_idx;
        rr_ptr <= ptr_inc(pick_idx);
      end
      if (state == ST_ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT && !mm_done) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (done_ok) begin
        rsp_data  <= mm_result;
        rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
        rsp_err   <= 1'b0;
      end else if (tmo_hit) begin
        rsp_data  <= '0;
        rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
        rsp_err   <= 1'b1;
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter with a stub multiplier (result = a+b,
// done three cycles after the start cycle, optionally suppressed).
module tb_mont_mul_arbiter;
  import mont_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int TOUT  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_a, req_b;
  logic [NREQ-1:0]        req_ready, rsp_valid;
  logic [WIDTH-1:0]       rsp_data, mm_a, mm_b, mm_result;
  logic                   rsp_err, mm_start, mm_done, busy;
  logic [1:0]             owner;
  logic [7:0]             err_count;

  logic                   stub_en, force_done;
  logic [1:0]             stub_cnt = '0;
  logic [WIDTH-1:0]       stub_res = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mont_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_done(mm_done), .mm_result(mm_result), .busy(busy), .owner(owner),
    .err_count(err_count)
  );

  always @(posedge clk) begin
    if (mm_start) begin
      stub_cnt <= 2'd3;
      stub_res <= mm_a + mm_b;
    end else if (stub_cnt != 2'd0) begin
      stub_cnt <= stub_cnt - 2'd1;
    end
  end
  assign mm_done   = (stub_en && stub_cnt == 2'd1) || force_done;
  assign mm_result = stub_res;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    stub_en = 1'b1; force_done = 1'b0;
    do_reset();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_req_ready", req_ready, 0);

    // single op latency: accept c0, start c1, rsp c5
    req_a[0 +: WIDTH] = 32'd5; req_b[0 +: WIDTH] = 32'd7;
    req_valid = 4'b0001;
    #1 chk("lat_ready", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    chk("lat_start", mm_start, 1);
    chk("lat_mm_a", mm_a, 5);
    chk("lat_mm_b", mm_b, 7);
    chk("lat_busy", busy, 1);
    chk("lat_ready_busy", req_ready, 0);
    cyc();
    chk("lat_start_once", mm_start, 0);
    cyc(); cyc();
    chk("lat_no_early_rsp", rsp_valid, 0);
    cyc();
    chk("lat_rsp_valid", rsp_valid, 4'b0001);
    chk("lat_rsp_data", rsp_data, 12);
    chk("lat_rsp_err", rsp_err, 0);
    chk("lat_idle", busy, 0);
    cyc();
    chk("lat_rsp_pulse", rsp_valid, 0);

    // all four requesting: round-robin 0..3, back-to-back every 5 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = i;
      req_b[i*WIDTH +: WIDTH] = 32'd10;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      #1 chk($sformatf("rr_ready%0d", k), req_ready, 4'b0001 << k);
      cyc(); req_valid[k] = 1'b0;
      chk($sformatf("rr_start%0d", k), mm_start, 1);
      chk($sformatf("rr_mm_a%0d", k), mm_a, k);
      repeat (4) cyc();
      chk($sformatf("rr_rsp_valid%0d", k), rsp_valid, 4'b0001 << k);
      chk($sformatf("rr_rsp_data%0d", k), rsp_data, k + 10);
    end
    req_valid = 4'b1111;
    #1 chk("rr_ptr_wrap", req_ready, 4'b0001);
    req_valid = '0;

    // fairness: req0 held, req2 raised mid-op wins next
    do_reset();
    req_a[0 +: WIDTH] = 32'd1; req_b[0 +: WIDTH] = 32'd1;
    req_valid = 4'b0001;
    #1 chk("fair_ready0", req_ready, 4'b0001);
    cyc(); cyc();
    req_a[2*WIDTH +: WIDTH] = 32'd20; req_b[2*WIDTH +: WIDTH] = 32'd2;
    req_valid[2] = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    chk("fair_rsp0_valid", rsp_valid, 4'b0001);
    chk("fair_rsp0_data", rsp_data, 2);
    chk("fair_ready2", req_ready, 4'b0100);
    cyc(); req_valid[2] = 1'b0;
    chk("fair_owner2", owner, 2);
    chk("fair_mm_a2", mm_a, 20);
    repeat (4) cyc();
    #1;
    chk("fair_rsp2_valid", rsp_valid, 4'b0100);
    chk("fair_rsp2_data", rsp_data, 22);
    chk("fair_ready_back0", req_ready, 4'b0001);
    req_valid = '0;

    // watchdog: no done -> error response at cycle 18
    do_reset();
    stub_en = 1'b0;
    req_a[1*WIDTH +: WIDTH] = 32'd9; req_b[1*WIDTH +: WIDTH] = 32'd9;
    req_valid = 4'b0010;
    #1 chk("tmo_ready", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    chk("tmo_start", mm_start, 1);
    repeat (16) cyc();
    chk("tmo_not_yet", rsp_valid, 0);
    chk("tmo_busy17", busy, 1);
    cyc();
    chk("tmo_rsp_valid", rsp_valid, 4'b0010);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    chk("tmo_err_count", err_count, 1);
    chk("tmo_idle", busy, 0);
    cyc(); force_done = 1'b1;
    cyc(); force_done = 1'b0;
    chk("tmo_late_done_rsp", rsp_valid, 0);
    chk("tmo_late_done_cnt", err_count, 1);
    chk("tmo_late_done_idle", busy, 0);
    stub_en = 1'b1;

    // reset during WAIT abandons the op; stale done ignored
    req_a[0 +: WIDTH] = 32'd100; req_b[0 +: WIDTH] = 32'd1;
    req_valid = 4'b0001;
    cyc(); req_valid = '0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    chk("wrst_busy", busy, 0);
    chk("wrst_rsp_valid", rsp_valid, 0);
    chk("wrst_mm_a", mm_a, 0);
    chk("wrst_mm_b", mm_b, 0);
    chk("wrst_err_count", err_count, 0);
    chk("wrst_owner", owner, 0);
    cyc(); cyc();
    chk("wrst_stale_rsp", rsp_valid, 0);
    chk("wrst_stale_idle", busy, 0);
    req_a[1*WIDTH +: WIDTH] = 32'd3; req_b[1*WIDTH +: WIDTH] = 32'd4;
    req_valid = 4'b0010;
    #1 chk("wrst_ready1", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    repeat (4) cyc();
    chk("wrst_rsp_valid1", rsp_valid, 4'b0010);
    chk("wrst_rsp_data1", rsp_data, 7);
    chk("wrst_rsp_err1", rsp_err, 0);

    // done while idle with no requests
    cyc(); force_done = 1'b1;
    cyc(); force_done = 1'b0;
    chk("idle_done_rsp", rsp_valid, 0);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_cnt", err_count, 0);
    cyc();
    chk("idle_done_rsp2", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
